// File: rtl/uart_tx_responder.sv
// uart_tx_responder: memory-mapped 8N1 UART transmitter on the toy CPU bus.
// The CPU pushes bytes into a small circular TX FIFO through a 4-word register
// window. A serializer drains the FIFO onto the registered tx pin.
module uart_tx_responder #(
    parameter logic [15:0] BASE_ADDR   = 16'h00C0,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus_addr,
    input  logic [15:0] bus_wdata,
    input  logic        bus_we,
    output logic [15:0] bus_rdata,
    output logic        bus_hit,
    output logic        tx,
    output logic        tx_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_DIVISOR = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Bus decode and write-strobe edge detection
    // ------------------------------------------------------------------
    logic [1:0] offset;
    logic       we_q, we_d;
    logic       wr_stb;

    assign bus_hit = (bus_addr[15:2] == BASE_ADDR[15:2]);
    assign offset  = bus_addr[1:0];
    // A held bus_we counts once: only the first cycle of a run is a write.
    assign we_d    = bus_we & bus_hit;
    assign wr_stb  = we_d & ~we_q;

    // ------------------------------------------------------------------
    // Register and FIFO state
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      divisor_q, divisor_d;

    logic full;
    logic empty;
    logic push_req;
    logic push;
    logic pop;

    // Serializer state
    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] div_q, div_d;
    logic        tx_q, tx_d;
    logic        baud_done;

    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign push_req = wr_stb && (offset == OFF_TXDATA);
    // Full is judged on the current count, so a push that coincides with a
    // pop from a full FIFO is still rejected.
    assign push     = push_req && !full;
    assign pop      = (state_q == S_IDLE) && !empty;

    assign tx       = tx_q;
    assign tx_busy  = (state_q != S_IDLE) || !empty;

    // Next-state for FIFO pointers, occupancy, overflow flag and divisor.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, otherwise a
        // path that skips the assignment would infer a latch.
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        divisor_d  = divisor_q;

        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (push_req && full) begin
            overflow_d = 1'b1;
        end else if (wr_stb && (offset == OFF_STATUS) && bus_wdata[3]) begin
            overflow_d = 1'b0;
        end

        if (wr_stb && (offset == OFF_DIVISOR)) begin
            // A zero divisor would never let the baud counter terminate.
            divisor_d = (bus_wdata == 16'd0) ? 16'd1 : bus_wdata;
        end
    end

    // Register the bus-side state.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            we_q       <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            divisor_q  <= DEFAULT_DIV;
        end else begin
            we_q       <= we_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            divisor_q  <= divisor_d;
        end
    end

    // Write accepted bytes into the FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; count/pointers define which
        // entries are valid, so clearing the data would only cost logic.
        if (push) begin
            mem_q[wptr_q] <= bus_wdata[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Serializer: 8N1, LSB first, each bit div_q clocks long
    // ------------------------------------------------------------------
    assign baud_done = (baud_q == div_q - 16'd1);

    // Next-state for the serializer FSM and the registered tx line.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        div_d   = div_q;
        tx_d    = tx_q;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    // Divisor is sampled per frame so mid-frame writes wait.
                    shift_d = mem_q[rptr_q];
                    div_d   = divisor_q;
                    baud_d  = 16'd0;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (baud_done) begin
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end

            S_DATA: begin
                if (baud_done) begin
                    baud_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        // Present the next bit on the same edge as the shift.
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end

            S_STOP: begin
                tx_d = 1'b1;
                if (baud_done) begin
                    baud_d  = 16'd0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end

            default: begin
                tx_d    = 1'b1;
                baud_d  = 16'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Register the serializer; reset drops tx high at once, aborting a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            div_q   <= DEFAULT_DIV;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            div_q   <= div_d;
            tx_q    <= tx_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux: purely combinational from address and current state
    // ------------------------------------------------------------------
    logic [3:0]  count_nib;
    assign count_nib = 4'(count_q);

    // Select read data for the addressed register.
    always_comb begin
        bus_rdata = 16'h0000;
        if (bus_hit) begin
            case (offset)
                OFF_STATUS:  bus_rdata = {8'h00, count_nib, overflow_q, tx_busy, empty, full};
                OFF_DIVISOR: bus_rdata = divisor_q;
                default:     bus_rdata = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_responder.sv
// Testbench for uart_tx_responder: register-read vector table plus directed
// sequences for frame timing, held strobes, overflow, divisor 0 and reset.
module tb_uart_tx_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_we;
    logic [15:0] bus_rdata;
    logic        bus_hit;
    logic        tx;
    logic        tx_busy;

    int tests  = 0;
    int fails  = 0;
    int cyc    = 0;
    int rx_div = 4;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        bit         clean;
        int         start;
    } frame_t;

    frame_t rx_q[$];

    typedef struct {
        logic [15:0] addr;
        logic [15:0] exp_rdata;
        logic        exp_hit;
    } vec_t;

    uart_tx_responder #(
        .BASE_ADDR  (16'h00C0),
        .FIFO_DEPTH (4),
        .DEFAULT_DIV(16'd434)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_we   (bus_we),
        .bus_rdata(bus_rdata),
        .bus_hit  (bus_hit),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d, output int t);
        @(negedge clk);
        bus_addr  = a;
        bus_wdata = d;
        bus_we    = 1'b1;
        t         = cyc;
        @(negedge clk);
        bus_we    = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output logic h);
        @(negedge clk);
        bus_addr = a;
        bus_we   = 1'b0;
        #1;
        d = bus_rdata;
        h = bus_hit;
    endtask

    task automatic wait_frames(input int n, input int limit);
        int k;
        k = 0;
        while (rx_q.size() < n && k < limit) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (rx_q.size() < n) check("wait_frames_timeout", rx_q.size(), n);
    endtask

    // Independent 8N1 receiver: samples tx every cycle, checks each bit is
    // stable for rx_div cycles and queues the decoded frame.
    initial begin
        int         pos;
        int         b;
        logic [9:0] fr;
        bit         clean;
        int         fstart;
        frame_t     f;
        pos = -1;
        fr  = '0;
        clean = 1'b1;
        fstart = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                pos = -1;
            end else begin
                if (pos < 0 && tx === 1'b0) begin
                    pos    = 0;
                    clean  = 1'b1;
                    fstart = cyc;
                end
                if (pos >= 0) begin
                    b = pos / rx_div;
                    if (pos % rx_div == 0) fr[b] = tx;
                    else if (tx !== fr[b]) clean = 1'b0;
                    pos++;
                    if (pos == 10 * rx_div) begin
                        f.data  = fr[8:1];
                        f.stop  = fr[9];
                        f.clean = clean;
                        f.start = fstart;
                        rx_q.push_back(f);
                        pos = -1;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[6];
        logic [15:0] d;
        logic        h;
        int          t;
        int          base;
        logic [7:0]  six[6];

        vecs[0] = '{16'h00C0, 16'h0000, 1'b1};
        vecs[1] = '{16'h00C1, 16'h0002, 1'b1};
        vecs[2] = '{16'h00C2, 16'h01B2, 1'b1};
        vecs[3] = '{16'h00C3, 16'h0000, 1'b1};
        vecs[4] = '{16'h00BF, 16'h0000, 1'b0};
        vecs[5] = '{16'h00C4, 16'h0000, 1'b0};

        rst       = 1'b0;
        bus_addr  = 16'h0000;
        bus_wdata = 16'h0000;
        bus_we    = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_busy", tx_busy, 1'b0);
        rst = 1'b0;

        // Register window after reset
        for (int i = 0; i < 6; i++) begin
            bus_read(vecs[i].addr, d, h);
            check($sformatf("rd_%h_data", vecs[i].addr), d, vecs[i].exp_rdata);
            check($sformatf("rd_%h_hit", vecs[i].addr), h, vecs[i].exp_hit);
        end
        check("idle_tx", tx, 1'b1);

        // Single frame 0xA5 at divisor 4
        bus_write(16'h00C2, 16'd4, t);
        bus_read(16'h00C2, d, h);
        check("div_rdback_4", d, 16'h0004);
        rx_div = 4;
        base = rx_q.size();
        bus_write(16'h00C0, 16'h00A5, t);
        wait_frames(base + 1, 200);
        if (rx_q.size() > base) begin
            check("a5_data", rx_q[base].data, 8'hA5);
            check("a5_stop", rx_q[base].stop, 1'b1);
            check("a5_clean", rx_q[base].clean, 1'b1);
            check("a5_latency", rx_q[base].start - t, 2);
            check("a5_busy_in_stop", tx_busy, 1'b1);
            @(negedge clk);
            #1;
            check("a5_busy_after", tx_busy, 1'b0);
            check("a5_tx_after", tx, 1'b1);
        end

        // Held strobe: three cycles of bus_we push one byte
        base = rx_q.size();
        @(negedge clk);
        bus_addr  = 16'h00C0;
        bus_wdata = 16'h0055;
        bus_we    = 1'b1;
        repeat (3) @(negedge clk);
        bus_we = 1'b0;
        bus_read(16'h00C1, d, h);
        check("hold_status", d, 16'h0006);
        wait_frames(base + 1, 200);
        if (rx_q.size() > base) check("hold_data", rx_q[base].data, 8'h55);
        repeat (60) @(negedge clk);
        #1;
        check("hold_one_frame", rx_q.size(), base + 1);

        // Six back-to-back writes: 1 popped, 4 queued, 1 dropped
        six = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        base = rx_q.size();
        for (int i = 0; i < 6; i++) bus_write(16'h00C0, {8'h00, six[i]}, t);
        bus_read(16'h00C1, d, h);
        check("six_status_full_ovf", d, 16'h004D);
        bus_read(16'h00C0, d, h);
        check("txdata_reads_zero", d, 16'h0000);
        wait_frames(base + 5, 400);
        for (int i = 0; i < 5; i++) begin
            if (rx_q.size() > base + i) begin
                check($sformatf("six_data_%0d", i), rx_q[base + i].data, six[i]);
                check($sformatf("six_clean_%0d", i), rx_q[base + i].clean, 1'b1);
                if (i > 0) check($sformatf("six_gap_%0d", i),
                                 rx_q[base + i].start - rx_q[base + i - 1].start, 41);
            end
        end
        repeat (60) @(negedge clk);
        #1;
        check("six_dropped", rx_q.size(), base + 5);
        bus_read(16'h00C1, d, h);
        check("ovf_sticky", d, 16'h000A);
        bus_write(16'h00C1, 16'h0008, t);
        bus_read(16'h00C1, d, h);
        check("ovf_cleared", d, 16'h0002);
        bus_write(16'h00C3, 16'hFFFF, t);
        bus_read(16'h00C3, d, h);
        check("reserved_reads_zero", d, 16'h0000);
        bus_read(16'h00C2, d, h);
        check("div_kept", d, 16'h0004);

        // Divisor 0 becomes 1: 10-cycle frame
        bus_write(16'h00C2, 16'h0000, t);
        bus_read(16'h00C2, d, h);
        check("div0_rdback", d, 16'h0001);
        rx_div = 1;
        base = rx_q.size();
        bus_write(16'h00C0, 16'h003C, t);
        wait_frames(base + 1, 100);
        if (rx_q.size() > base) begin
            check("div1_data", rx_q[base].data, 8'h3C);
            check("div1_clean", rx_q[base].clean, 1'b1);
            check("div1_latency", rx_q[base].start - t, 2);
        end
        repeat (5) @(negedge clk);

        // Reset during DATA bit 3, with a second byte waiting in the FIFO
        bus_write(16'h00C2, 16'd4, t);
        rx_div = 4;
        bus_write(16'h00C0, 16'h0000, t);
        bus_write(16'h00C0, 16'h00FF, base);
        base = rx_q.size();
        while (cyc < t + 19) @(negedge clk);
        check("bit3_low", tx, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("rst_tx_async", tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus_read(16'h00C1, d, h);
        check("rst_status", d, 16'h0002);
        bus_read(16'h00C2, d, h);
        check("rst_divisor", d, 16'h01B2);
        repeat (60) @(negedge clk);
        #1;
        check("rst_no_frame", rx_q.size(), base);
        check("rst_tx_idle", tx, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
